// File: rtl/ring_delay_pkg.sv
// ring_delay_pkg: shared helpers for the programmable ring-buffer delay line.
// Helpers take 32-bit arguments; callers cast to and from their own widths.
package ring_delay_pkg;

  localparam int unsigned RD_WIDTH_DEF = 8;
  localparam int unsigned RD_DEPTH_DEF = 8;

  // Map a requested delay onto the legal range 1..depth.
  function automatic int unsigned clamp_delay(input int unsigned req,
                                              input int unsigned depth);
    if (req == 32'd0) return 32'd1;
    if (req > depth) return depth;
    return req;
  endfunction

  // (a - b) mod depth for a < depth and b <= depth, wrapped by compare/add.
  function automatic int unsigned wrap_sub(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned depth);
    if (a >= b) return a - b;
    return a + depth - b;
  endfunction

  // Fill state restarts on a flush or on any change of the effective delay.
  function automatic logic reload_needed(input logic        flush,
                                         input int unsigned clamped,
                                         input int unsigned current);
    return flush || (clamped != current);
  endfunction

endpackage

// File: rtl/ring_delay_if.sv
// ring_delay_if: sample stream, delay control and status of one delay line.
interface ring_delay_if
  import ring_delay_pkg::*;
#(
  parameter int unsigned WIDTH = RD_WIDTH_DEF,
  parameter int unsigned DEPTH = RD_DEPTH_DEF
) ();

  localparam int unsigned DW = $clog2(DEPTH + 1);

  logic             enable_i;
  logic             flush_i;
  logic [DW-1:0]    delay_i;
  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic [DW-1:0]    fill_o;

  modport master (
    output enable_i, flush_i, delay_i, data_i,
    input  data_o, valid_o, fill_o
  );

  modport slave (
    input  enable_i, flush_i, delay_i, data_i,
    output data_o, valid_o, fill_o
  );

endinterface

// File: rtl/ring_delay_mem.sv
// ring_delay_mem: DEPTH x WIDTH storage, one synchronous write port and one
// asynchronous read port. Kept separate so a vendor RAM can replace it.
module ring_delay_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port; entries are never reset, readers mask stale data.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ring_delay.sv
// ring_delay: run-time programmable delay line built on a wrapping ring buffer.
// Optional macro RING_DELAY_OREG_EN adds a one-cycle output register on
// data_o/valid_o; fill_o is never registered twice.
module ring_delay
  import ring_delay_pkg::*;
#(
  parameter int unsigned WIDTH = RD_WIDTH_DEF,
  parameter int unsigned DEPTH = RD_DEPTH_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  ring_delay_if.slave  bus
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wp_q;
  logic [AW-1:0]    rd_addr_c;
  logic [DW-1:0]    fill_q;
  logic [DW-1:0]    delay_q;
  logic [DW-1:0]    delay_clamp_c;
  logic             reload_c;
  logic             valid_c;
  logic [WIDTH-1:0] rd_data_c;
  logic [WIDTH-1:0] data_c;

  ring_delay_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (bus.enable_i),
    .waddr_i (wp_q),
    .wdata_i (bus.data_i),
    .raddr_i (rd_addr_c),
    .rdata_o (rd_data_c)
  );

  // Clamp request, detect reload, locate the tap and mask unfilled output.
  always_comb begin
    delay_clamp_c = DW'(clamp_delay(32'(bus.delay_i), DEPTH));
    reload_c      = reload_needed(bus.flush_i, 32'(delay_clamp_c), 32'(delay_q));
    rd_addr_c     = AW'(wrap_sub(32'(wp_q), 32'(delay_q), DEPTH));
    valid_c       = (fill_q >= delay_q);
    data_c        = valid_c ? rd_data_c : '0;
  end

  // Write pointer, fill count and effective delay.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q    <= '0;
      fill_q  <= '0;
      delay_q <= DW'(1);
    end else begin
      if (bus.enable_i) begin
        wp_q <= (wp_q == AW'(DEPTH - 1)) ? '0 : wp_q + AW'(1);
      end
      if (reload_c) begin
        delay_q <= delay_clamp_c;
        fill_q  <= bus.enable_i ? DW'(1) : '0;
      end else if (bus.enable_i && (fill_q != DW'(DEPTH))) begin
        fill_q <= fill_q + DW'(1);
      end
    end
  end

  assign bus.fill_o = fill_q;

`ifdef RING_DELAY_OREG_EN
  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  // Output register, refreshed every clock regardless of enable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_c;
      valid_q <= valid_c;
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
`else
  assign bus.data_o  = data_c;
  assign bus.valid_o = valid_c;
`endif

endmodule

// File: tb/tb_ring_delay.sv
// tb_ring_delay: directed and random stimulus against a history-queue model.
module tb_ring_delay;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  // Behavioural model: every enabled sample in a queue, plus fill and delay.
  logic [7:0] hist[$];
  int         m_fill  = 0;
  int         m_delay = 1;
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;

  ring_delay_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  ring_delay #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want normal end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // Output seen D enabled samples back, masked until D samples since restart.
  task automatic model_eval();
    m_valid = (m_fill >= m_delay);
    m_data  = m_valid ? hist[hist.size() - m_delay] : 8'h00;
  endtask

  // Advance the model on every edge, then compare the DUT just after it.
  always @(posedge clk) begin
    logic [7:0] prev_data;
    logic       prev_valid;
    logic [7:0] e_data;
    logic       e_valid;
    int         cl;
    prev_data  = m_data;
    prev_valid = m_valid;
    if (rst) begin
      m_fill  = 0;
      m_delay = 1;
    end else begin
      cl = int'(bus.delay_i);
      if (cl == 0) cl = 1;
      if (cl > int'(DEPTH)) cl = int'(DEPTH);
      if (bus.flush_i || (cl != m_delay)) begin
        m_delay = cl;
        m_fill  = bus.enable_i ? 1 : 0;
      end else if (bus.enable_i && (m_fill < int'(DEPTH))) begin
        m_fill++;
      end
      if (bus.enable_i) begin
        hist.push_back(bus.data_i);
        if (hist.size() > 32) void'(hist.pop_front());
      end
    end
    model_eval();
    if (rst) begin
      e_data  = 8'h00;
      e_valid = 1'b0;
    end else begin
`ifdef RING_DELAY_OREG_EN
      e_data  = prev_data;
      e_valid = prev_valid;
`else
      e_data  = m_data;
      e_valid = m_valid;
`endif
    end
    #1;
    chk("valid_o", 32'(bus.valid_o), 32'(e_valid));
    chk("data_o",  32'(bus.data_o),  32'(e_data));
    chk("fill_o",  32'(bus.fill_o),  32'(m_fill));
  end

  // One clock: drive on the falling edge, return just after the rising edge.
  task automatic cyc(input logic en, input logic fl, input int d, input logic [7:0] dat);
    @(negedge clk);
    bus.enable_i = en;
    bus.flush_i  = fl;
    bus.delay_i  = 4'(d);
    bus.data_i   = dat;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.enable_i = 1'b0;
    bus.flush_i  = 1'b0;
    bus.data_i   = 8'h00;
    #1;
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_data",  32'(bus.data_o),  32'd0);
    chk("rst_fill",  32'(bus.fill_o),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int k;
    int cur_d;
    rst          = 1'b1;
    bus.enable_i = 1'b0;
    bus.flush_i  = 1'b0;
    bus.delay_i  = 4'd3;
    bus.data_i   = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset scenario: D=3, data 1,2,3,...
    for (int n = 1; n <= 12; n++) begin
      cyc(1'b1, 1'b0, 3, 8'(n));
      if (n == 2)  chk("m_s1_valid2", 32'(m_valid), 32'd0);
      if (n == 3)  begin chk("m_s1_valid3", 32'(m_valid), 32'd1); chk("m_s1_data3", 32'(m_data), 32'd1); end
      if (n == 10) begin chk("m_s1_data10", 32'(m_data), 32'd8); chk("m_s1_fill10", 32'(m_fill), 32'd8); end
    end

    // Enable gaps on alternate cycles.
    do_reset();
    k = 0;
    for (int i = 0; i < 24; i++) begin
      if ((i % 2) == 0) begin
        k++;
        cyc(1'b1, 1'b0, 3, 8'(k));
      end else begin
        cyc(1'b0, 1'b0, 3, 8'($urandom));
      end
      if (i == 4) begin chk("m_s2_valid", 32'(m_valid), 32'd1); chk("m_s2_data", 32'(m_data), 32'd1); end
      if (i == 5) begin chk("m_s2_hold",  32'(m_data),  32'd1); chk("m_s2_fillh", 32'(m_fill), 32'd3); end
      if (i == 22) chk("m_s2_data12", 32'(m_data), 32'd10);
    end

    // Wrap-around at maximum delay.
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      cyc(1'b1, 1'b0, 8, 8'(n));
      if (n == 7)  chk("m_s3_valid7", 32'(m_valid), 32'd0);
      if (n == 8)  begin chk("m_s3_valid8", 32'(m_valid), 32'd1); chk("m_s3_data8", 32'(m_data), 32'd1); end
      if (n == 20) chk("m_s3_data20", 32'(m_data), 32'd13);
    end

    // Delay change 3 -> 5 mid-stream, then flush with unchanged delay.
    do_reset();
    for (int n = 1; n <= 10; n++) cyc(1'b1, 1'b0, 3, 8'(n));
    cyc(1'b1, 1'b0, 5, 8'd11);
    chk("m_s4_fill", 32'(m_fill), 32'd1);
    chk("m_s4_valid", 32'(m_valid), 32'd0);
    for (int n = 12; n <= 15; n++) cyc(1'b1, 1'b0, 5, 8'(n));
    chk("m_s4_data15", 32'(m_data), 32'd11);
    cyc(1'b1, 1'b1, 5, 8'd16);
    chk("m_s5_fill", 32'(m_fill), 32'd1);
    for (int n = 17; n <= 20; n++) cyc(1'b1, 1'b0, 5, 8'(n));
    chk("m_s5_data20", 32'(m_data), 32'd16);
    cyc(1'b0, 1'b1, 5, 8'd0);
    chk("m_s5_idle_flush", 32'(m_fill), 32'd0);
    cyc(1'b0, 1'b0, 2, 8'd0);
    cyc(1'b0, 1'b0, 2, 8'd0);

    // Clamping: 0 acts as 1, 15 acts as 8.
    do_reset();
    for (int n = 1; n <= 4; n++) begin
      cyc(1'b1, 1'b0, 0, 8'(n));
      if (n == 1) chk("m_s6_d0_data1", 32'(m_data), 32'd1);
    end
    for (int n = 5; n <= 12; n++) cyc(1'b1, 1'b0, 15, 8'(n));
    chk("m_s6_d15_data", 32'(m_data), 32'd5);

    // Asynchronous reset mid-stream at delay 4, fill 6.
    do_reset();
    for (int n = 1; n <= 6; n++) cyc(1'b1, 1'b0, 4, 8'(n));
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.valid_o), 32'd0);
    chk("arst_data",  32'(bus.data_o),  32'd0);
    chk("arst_fill",  32'(bus.fill_o),  32'd0);
    @(negedge clk);
    bus.enable_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      cyc(1'b1, 1'b0, 3, 8'(n));
      if (n == 3) chk("m_s7_data3", 32'(m_data), 32'd1);
    end

    // Random traffic with occasional flushes, delay changes and a reset.
    do_reset();
    cur_d = 3;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) cur_d = int'($urandom_range(0, 15));
      if (i == 300) do_reset();
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0, cur_d, 8'($urandom));
    end

    cyc(1'b0, 1'b0, cur_d, 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
